// File: rtl/lfsr_checker.sv
// ----------------------------------------------------------------------------
// lfsr / lfsr_checker
//
// lfsr: 32-bit Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1, shifting
// left with the feedback bit entering at bit 0. o_lfsr is the current word;
// i_en advances it by one step, and i_rst_seed loads i_seed_data.
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (state = 1, never all-zero)
//   i_rst_seed   synchronous seed load, priority over i_en
//   i_seed_data  seed value
//   i_en         advance one step
//   o_lfsr       current LFSR word
//
// lfsr_checker: receive-side checker for the LFSR test-pattern generator.
// A packet is a maximal run of i_valid=1 bytes: a 4-byte big-endian packet
// count followed by 32-bit LFSR words, MSB byte first. Status is reported one
// cycle after the terminating i_valid=0 cycle.
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset
//   i_rst_seed     synchronous: reseed LFSR, reload count, clear totals
//   i_seed_data    LFSR seed, same value as the transmitter
//   i_valid        byte valid
//   i_data         received byte
//   o_pkt_done     one-cycle pulse, packet status valid
//   o_pkt_good     packet had no errors
//   o_runt         packet shorter than 4 bytes
//   o_count_err    packet count field mismatched
//   o_payload_err  mismatched payload bytes in the packet, saturating
//   o_total_pkts   packets completed, saturating
//   o_bad_pkts     packets with o_pkt_good=0, saturating
// ----------------------------------------------------------------------------

module lfsr (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rst_seed,
    input  logic [31:0] i_seed_data,
    input  logic        i_en,
    output logic [31:0] o_lfsr
);

    logic [31:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    assign o_lfsr   = lfsr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q <= 32'h0000_0001;
        end else if (i_rst_seed) begin
            lfsr_q <= i_seed_data;
        end else if (i_en) begin
            lfsr_q <= {lfsr_q[30:0], feedback};
        end
    end

endmodule

module lfsr_checker #(
    parameter logic [31:0] COUNT_INIT = 32'h0123_4567,
    parameter bit          RESYNC     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rst_seed,
    input  logic [31:0] i_seed_data,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_pkt_done,
    output logic        o_pkt_good,
    output logic        o_runt,
    output logic        o_count_err,
    output logic [15:0] o_payload_err,
    output logic [31:0] o_total_pkts,
    output logic [31:0] o_bad_pkts
);

    typedef enum logic [1:0] {StIdle, StCount, StPayload} state_e;

    state_e      state_q;
    logic [1:0]  idx_q;        // byte index within count field or payload word
    logic [31:0] exp_cnt_q;    // expected packet count
    logic [31:0] cap_cnt_q;    // received packet count, shifted in MSB first
    logic [31:0] shadow_q;     // current payload word, bytes 2..4 compared from here
    logic        cerr_acc_q;
    logic [15:0] perr_acc_q;

    logic        pkt_done_q;
    logic        pkt_good_q;
    logic        runt_q;
    logic        count_err_q;
    logic [15:0] payload_err_q;
    logic [31:0] total_q;
    logic [31:0] bad_q;

    logic [31:0] lfsr_out;
    logic        lfsr_en;
    logic [7:0]  cnt_byte;
    logic [7:0]  pay_byte;
    logic        cnt_mis;
    logic        pay_mis;
    logic        eop;
    logic        eop_runt;
    logic        eop_good;
    logic [15:0] perr_inc;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        unique case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    // idx_q is 0 in StIdle, so the same mux serves the first count byte.
    assign cnt_byte = byte_sel(exp_cnt_q, idx_q);
    assign pay_byte = (idx_q == 2'd0) ? lfsr_out[31:24] : byte_sel(shadow_q, idx_q);
    assign cnt_mis  = (i_data != cnt_byte);
    assign pay_mis  = (i_data != pay_byte);
    assign perr_inc = (perr_acc_q != 16'hFFFF) ? perr_acc_q + 16'd1 : perr_acc_q;

    assign eop      = (state_q != StIdle) && !i_valid;
    assign eop_runt = (state_q == StCount);
    assign eop_good = !eop_runt && !cerr_acc_q && (perr_acc_q == 16'd0);

    // Step on the first byte of each word so a partial word at packet end has
    // already consumed its LFSR step, matching the transmitter.
    assign lfsr_en  = (state_q == StPayload) && i_valid && (idx_q == 2'd0) && !i_rst_seed;

    lfsr u_lfsr (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rst_seed  (i_rst_seed),
        .i_seed_data (i_seed_data),
        .i_en        (lfsr_en),
        .o_lfsr      (lfsr_out)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            exp_cnt_q     <= COUNT_INIT;
            cap_cnt_q     <= 32'd0;
            shadow_q      <= 32'd0;
            cerr_acc_q    <= 1'b0;
            perr_acc_q    <= 16'd0;
            pkt_done_q    <= 1'b0;
            pkt_good_q    <= 1'b0;
            runt_q        <= 1'b0;
            count_err_q   <= 1'b0;
            payload_err_q <= 16'd0;
            total_q       <= 32'd0;
            bad_q         <= 32'd0;
        end else begin
            pkt_done_q <= 1'b0;
            if (i_rst_seed) begin
                // Abandon any packet in progress without reporting it.
                state_q   <= StIdle;
                idx_q     <= 2'd0;
                exp_cnt_q <= COUNT_INIT;
                total_q   <= 32'd0;
                bad_q     <= 32'd0;
            end else if (eop) begin
                pkt_done_q    <= 1'b1;
                pkt_good_q    <= eop_good;
                runt_q        <= eop_runt;
                count_err_q   <= cerr_acc_q;
                payload_err_q <= perr_acc_q;
                if (total_q != 32'hFFFF_FFFF) begin
                    total_q <= total_q + 32'd1;
                end
                if (!eop_good && (bad_q != 32'hFFFF_FFFF)) begin
                    bad_q <= bad_q + 32'd1;
                end
                // A runt's captured count is incomplete, so it never resyncs.
                if (RESYNC && cerr_acc_q && !eop_runt) begin
                    exp_cnt_q <= cap_cnt_q + 32'd1;
                end else begin
                    exp_cnt_q <= exp_cnt_q + 32'd1;
                end
                state_q <= StIdle;
                idx_q   <= 2'd0;
            end else if (i_valid) begin
                unique case (state_q)
                    StIdle: begin
                        cerr_acc_q <= cnt_mis;
                        perr_acc_q <= 16'd0;
                        cap_cnt_q  <= {24'd0, i_data};
                        idx_q      <= 2'd1;
                        state_q    <= StCount;
                    end
                    StCount: begin
                        cerr_acc_q <= cerr_acc_q | cnt_mis;
                        cap_cnt_q  <= {cap_cnt_q[23:0], i_data};
                        if (idx_q == 2'd3) begin
                            idx_q   <= 2'd0;
                            state_q <= StPayload;
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                    StPayload: begin
                        if (idx_q == 2'd0) begin
                            shadow_q <= lfsr_out;
                        end
                        if (pay_mis) begin
                            perr_acc_q <= perr_inc;
                        end
                        idx_q <= idx_q + 2'd1;
                    end
                    default: begin
                        state_q <= StIdle;
                        idx_q   <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign o_pkt_done    = pkt_done_q;
    assign o_pkt_good    = pkt_good_q;
    assign o_runt        = runt_q;
    assign o_count_err   = count_err_q;
    assign o_payload_err = payload_err_q;
    assign o_total_pkts  = total_q;
    assign o_bad_pkts    = bad_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// ----------------------------------------------------------------------------
// tb_lfsr_checker: two checker instances (RESYNC=1 at index 1, RESYNC=0 at
// index 0) fed the same stream from a transmitter model. Expected status comes
// from a packet-level model: each packet's received bytes are compared with
// the clean transmitted bytes and with the model's expected count.
// ----------------------------------------------------------------------------

module tb_lfsr_checker;

    localparam logic [31:0] CINIT = 32'h0123_4567;
    localparam logic [31:0] SEED  = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_seed;
    logic [31:0] seed_data;
    logic        valid;
    logic [7:0]  data;

    logic        pkt_done    [2];
    logic        pkt_good    [2];
    logic        runt        [2];
    logic        count_err   [2];
    logic [15:0] payload_err [2];
    logic [31:0] total_pkts  [2];
    logic [31:0] bad_pkts    [2];

    int checks   = 0;
    int failures = 0;

    // Transmitter / reference model state
    logic [31:0] tx_word;
    logic [31:0] tx_cnt;
    logic [31:0] m_exp   [2];
    logic [31:0] m_total [2];
    logic [31:0] m_bad   [2];
    int          m_done  [2];
    int          done_seen [2];

    always #5 clk = ~clk;

    lfsr_checker #(.COUNT_INIT(CINIT), .RESYNC(1'b0)) dut_r0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_seed(rst_seed), .i_seed_data(seed_data),
        .i_valid(valid), .i_data(data), .o_pkt_done(pkt_done[0]), .o_pkt_good(pkt_good[0]),
        .o_runt(runt[0]), .o_count_err(count_err[0]), .o_payload_err(payload_err[0]),
        .o_total_pkts(total_pkts[0]), .o_bad_pkts(bad_pkts[0])
    );

    lfsr_checker #(.COUNT_INIT(CINIT), .RESYNC(1'b1)) dut_r1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rst_seed(rst_seed), .i_seed_data(seed_data),
        .i_valid(valid), .i_data(data), .o_pkt_done(pkt_done[1]), .o_pkt_good(pkt_good[1]),
        .o_runt(runt[1]), .o_count_err(count_err[1]), .o_payload_err(payload_err[1]),
        .o_total_pkts(total_pkts[1]), .o_bad_pkts(bad_pkts[1])
    );

    initial begin
        done_seen[0] = 0;
        done_seen[1] = 0;
    end

    always @(negedge clk) begin
        if (pkt_done[0] === 1'b1) done_seen[0] <= done_seen[0] + 1;
        if (pkt_done[1] === 1'b1) done_seen[1] <= done_seen[1] + 1;
    end

    // Polynomial x^32 + x^22 + x^2 + x + 1, expressed by its tap list.
    function automatic logic [31:0] lfsr_next(input logic [31:0] w);
        int   taps [4];
        logic fb;
        taps = '{32, 22, 2, 1};
        fb = 1'b0;
        foreach (taps[i]) fb = fb ^ w[taps[i] - 1];
        return {w[30:0], fb};
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[r%0d] actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reseed();
        rst_seed  = 1'b1;
        seed_data = SEED;
        valid     = 1'b0;
        tick();
        rst_seed = 1'b0;
        tx_word  = SEED;
        tx_cnt   = CINIT;
        for (int k = 0; k < 2; k++) begin
            m_exp[k]   = CINIT;
            m_total[k] = 32'd0;
            m_bad[k]   = 32'd0;
        end
    endtask

    task automatic check_totals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_total"}, k, total_pkts[k], m_total[k]);
            chk({tag, "_bad"}, k, bad_pkts[k], m_bad[k]);
        end
    endtask

    // Send one packet of len bytes. ovr replaces the transmitted count; fa/fb
    // are byte offsets to corrupt (-1 = none). use_exp adds table constants.
    task automatic send_pkt(input int len, input bit ovr, input logic [31:0] ovr_cnt,
                            input int fa, input int fb, input bit use_exp,
                            input bit eg1, input bit eg0, input bit ec1, input bit ec0,
                            input bit er, input int ep);
        logic [7:0]  clean [$];
        logic [7:0]  q [$];
        logic [31:0] cnt;
        logic [31:0] cap;
        int          nw;
        bit          m_runt;
        bit          m_cerr;
        int          m_perr;
        bit          m_good;
        cnt    = ovr ? ovr_cnt : tx_cnt;
        tx_cnt = tx_cnt + 32'd1;
        for (int i = 0; i < 4; i++) clean.push_back(cnt[31 - 8*i -: 8]);
        nw = (len > 4) ? (len - 1) / 4 : 0;
        for (int j = 0; j < nw; j++) begin
            for (int b = 0; b < 4; b++) clean.push_back(tx_word[31 - 8*b -: 8]);
            tx_word = lfsr_next(tx_word);
        end
        while (clean.size() > len) void'(clean.pop_back());
        q = clean;
        if (fa >= 0 && fa < len) q[fa] = q[fa] ^ 8'h01;
        if (fb >= 0 && fb < len) q[fb] = q[fb] ^ 8'h02;

        for (int i = 0; i < len; i++) begin
            valid = 1'b1;
            data  = q[i];
            tick();
        end
        valid = 1'b0;
        data  = 8'($urandom);
        tick();

        for (int k = 0; k < 2; k++) begin
            m_runt = (len < 4);
            m_cerr = 1'b0;
            for (int i = 0; i < 4 && i < len; i++) begin
                if (q[i] != m_exp[k][31 - 8*i -: 8]) m_cerr = 1'b1;
            end
            m_perr = 0;
            for (int i = 4; i < len; i++) if (q[i] != clean[i]) m_perr++;
            m_good = !m_runt && !m_cerr && (m_perr == 0);
            m_total[k] = m_total[k] + 32'd1;
            if (!m_good) m_bad[k] = m_bad[k] + 32'd1;
            m_done[k]++;
            if (!m_runt) begin
                cap = {q[0], q[1], q[2], q[3]};
                m_exp[k] = (k == 1 && m_cerr) ? cap + 32'd1 : m_exp[k] + 32'd1;
            end else begin
                m_exp[k] = m_exp[k] + 32'd1;
            end
            chk("pkt_done", k, {31'd0, pkt_done[k]}, 32'd1);
            chk("pkt_good", k, {31'd0, pkt_good[k]}, {31'd0, m_good});
            chk("runt", k, {31'd0, runt[k]}, {31'd0, m_runt});
            chk("count_err", k, {31'd0, count_err[k]}, {31'd0, m_cerr});
            chk("payload_err", k, {16'd0, payload_err[k]}, 32'(m_perr));
            chk("total_pkts", k, total_pkts[k], m_total[k]);
            chk("bad_pkts", k, bad_pkts[k], m_bad[k]);
            if (use_exp) begin
                chk("tbl_good", k, {31'd0, pkt_good[k]}, {31'd0, (k == 1) ? eg1 : eg0});
                chk("tbl_cerr", k, {31'd0, count_err[k]}, {31'd0, (k == 1) ? ec1 : ec0});
                chk("tbl_runt", k, {31'd0, runt[k]}, {31'd0, er});
                chk("tbl_perr", k, {16'd0, payload_err[k]}, 32'(ep));
            end
        end
    endtask

    typedef struct {
        int          len;
        bit          ovr;
        logic [31:0] cnt;
        int          fa;
        int          fb;
        bit          good1;
        bit          good0;
        bit          cerr1;
        bit          cerr0;
        int          perr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int len;
        int fa;
        int fb;
        bit ovr;
        logic [31:0] c;

        tbl[0] = '{64, 1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{64, 1'b0, 32'h0, 14, 15, 1'b0, 1'b0, 1'b0, 1'b0, 2};
        tbl[2] = '{64, 1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3] = '{5,  1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[4] = '{7,  1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[5] = '{4,  1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[6] = '{9,  1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[7] = '{8,  1'b1, 32'h0123_4599, -1, -1, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[8] = '{12, 1'b1, 32'h0123_459A, -1, -1, 1'b1, 1'b0, 1'b0, 1'b1, 0};

        m_done[0] = 0;
        m_done[1] = 0;
        rst_n     = 1'b0;
        rst_seed  = 1'b0;
        seed_data = 32'd0;
        valid     = 1'b0;
        data      = 8'd0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_done", k, {31'd0, pkt_done[k]}, 32'd0);
            chk("rst_good", k, {31'd0, pkt_good[k]}, 32'd0);
            chk("rst_perr", k, {16'd0, payload_err[k]}, 32'd0);
            chk("rst_total", k, total_pkts[k], 32'd0);
        end
        rst_n = 1'b1;
        tick();
        reseed();

        // Table: back-to-back packets, corruption, partial words, count resync.
        for (int t = 0; t < 9; t++) begin
            send_pkt(tbl[t].len, tbl[t].ovr, tbl[t].cnt, tbl[t].fa, tbl[t].fb, 1'b1,
                     tbl[t].good1, tbl[t].good0, tbl[t].cerr1, tbl[t].cerr0, 1'b0,
                     tbl[t].perr);
            if (t == 2) begin
                for (int k = 0; k < 2; k++) begin
                    chk("three_total", k, total_pkts[k], 32'd3);
                    chk("three_bad", k, bad_pkts[k], 32'd1);
                end
            end
        end

        // Runt followed by a good packet carrying the next count.
        reseed();
        send_pkt(2, 1'b0, 32'h0, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_pkt(16, 1'b1, 32'h0123_4568, -1, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Reseed mid-payload: packet abandoned, no status pulse, totals cleared.
        repeat (10) begin
            valid = 1'b1;
            data  = 8'($urandom);
            tick();
        end
        rst_seed  = 1'b1;
        seed_data = SEED;
        repeat (2) begin
            data = 8'($urandom);
            tick();
        end
        rst_seed = 1'b0;
        valid    = 1'b0;
        tx_word  = SEED;
        tx_cnt   = CINIT;
        for (int k = 0; k < 2; k++) begin
            m_exp[k]   = CINIT;
            m_total[k] = 32'd0;
            m_bad[k]   = 32'd0;
        end
        repeat (3) tick();
        for (int k = 0; k < 2; k++) chk("abort_no_done", k, 32'(done_seen[k]), 32'(m_done[k]));
        check_totals("abort");
        send_pkt(16, 1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Randomized traffic against the packet-level model.
        reseed();
        for (int p = 0; p < 30; p++) begin
            len = 4 + $urandom_range(0, 36);
            ovr = ($urandom_range(0, 5) == 0);
            c   = tx_cnt ^ (32'd1 << $urandom_range(0, 31));
            fa  = (len > 4 && $urandom_range(0, 2) == 0) ? $urandom_range(4, len - 1) : -1;
            fb  = (len > 4 && $urandom_range(0, 3) == 0) ? $urandom_range(4, len - 1) : -1;
            send_pkt(len, ovr, c, fa, fb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            if ($urandom_range(0, 3) == 0) begin
                valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        repeat (2) tick();
        for (int k = 0; k < 2; k++) chk("done_count", k, 32'(done_seen[k]), 32'(m_done[k]));

        // Asynchronous reset mid-packet clears every output immediately.
        repeat (6) begin
            valid = 1'b1;
            data  = 8'($urandom);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_done", k, {31'd0, pkt_done[k]}, 32'd0);
            chk("arst_good", k, {31'd0, pkt_good[k]}, 32'd0);
            chk("arst_runt", k, {31'd0, runt[k]}, 32'd0);
            chk("arst_cerr", k, {31'd0, count_err[k]}, 32'd0);
            chk("arst_perr", k, {16'd0, payload_err[k]}, 32'd0);
            chk("arst_total", k, total_pkts[k], 32'd0);
            chk("arst_bad", k, bad_pkts[k], 32'd0);
        end
        valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        reseed();
        send_pkt(13, 1'b0, 32'h0, -1, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the LFSR test-pattern generator: consumes the byte stream the generator emits and checks it byte by byte.
- Each packet carries a 4-byte big-endian packet count, then a run of 32-bit LFSR words, MSB byte first.
- Reports per-packet status and running totals for link bring-up and BER measurement on the RGMII path.
- Sits after the Ethernet receive byte stream; instantiates the team's 32-bit lfsr module, seeded identically to the transmitter.

Parameters:
- COUNT_INIT, 32'h01234567, expected packet count after seed reset
- RESYNC, 1, 1 = on a count mismatch, adopt the received count as the new expected base

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_rst_seed  input  1  synchronous: reseed LFSR, reload count, clear totals
- i_seed_data  input  32  LFSR seed, same value as the transmitter
- i_valid  input  1  byte valid; a packet is one maximal run of i_valid=1
- i_data  input  8  received byte
- o_pkt_done  output  1  one-cycle pulse, packet status valid
- o_pkt_good  output  1  packet had no errors (valid with o_pkt_done)
- o_runt  output  1  packet shorter than 4 bytes
- o_count_err  output  1  packet count field mismatched
- o_payload_err  output  16  mismatched payload bytes in the packet, saturating
- o_total_pkts  output  32  packets completed, saturating
- o_bad_pkts  output  32  packets with o_pkt_good=0, saturating

Behaviour:
- Reset (i_rst_n=0, async):
  - All outputs 0.
  - Expected count = COUNT_INIT.
  - State S_IDLE; lfsr instance held in its reset/seed path.
- i_rst_seed=1 (priority over i_valid):
  - Reseed lfsr (drive its i_rst_seed); expected count = COUNT_INIT; o_total_pkts and o_bad_pkts = 0.
  - Any packet in progress is abandoned with no o_pkt_done. Return to S_IDLE.
  - Bytes arriving while i_rst_seed=1 are ignored.
- States:
  - S_IDLE:
    - i_valid=1: compare the byte with count[31:24], set byte index 1, clear per-packet accumulators, go to S_COUNT.
  - S_COUNT:
    - i_valid=1: compare the byte with expected count byte [index]; shift the received byte into the captured count.
    - After the 4th byte, go to S_PAYLOAD.
    - i_valid=0: end of packet, runt if fewer than 4 bytes received.
  - S_PAYLOAD, per byte:
    - First byte of a word: expected byte = lfsr_out[31:24]. Load the shadow register with lfsr_out. Pulse the lfsr enable for one cycle.
    - Bytes 2..4 of a word: compare against shadow bytes [23:16], [15:8], [7:0].
    - Mismatch: o_payload_err += 1 (saturate at 16'hFFFF).
    - i_valid=0: end of packet.
- Word alignment:
  - Every packet's payload starts a new word.
  - A partially consumed word at packet end is discarded; the LFSR has already stepped for it, matching the transmitter.
- End of packet (the first i_valid=0 cycle after a run):
  - Next cycle: o_pkt_done=1 for exactly one cycle; o_runt, o_count_err, o_payload_err, o_pkt_good registered and held until the next o_pkt_done.
  - o_pkt_good = !runt & !count_err & (payload_err==0).
  - o_total_pkts += 1; o_bad_pkts += 1 when not good. Both saturate at all-ones.
  - Expected count update:
    - RESYNC=1 and count_err: expected = captured count + 1.
    - Otherwise: expected = expected + 1, wrapping modulo 2^32.
  - Runt packets: expected count still advances by 1; no LFSR step occurs.
  - Return to S_IDLE. A new packet can start on the cycle immediately after the i_valid=0 cycle.
- Payload length is unbounded; the byte index wraps mod 4.
- A zero-length payload (exactly 4 bytes) is legal and good if the count matches.
- Latency: status appears 1 cycle after the terminating i_valid=0 cycle.

Test Plan:
- Seed 32'hACE1_0001, generator → checker, 3 packets of 64 bytes: first count bytes are 01 23 45 67, then 01 23 45 68 → 3 o_pkt_done pulses, all o_pkt_good=1, o_total_pkts=3, o_bad_pkts=0.
- Flip bit 0 of payload bytes 10 and 11 in packet 2: packet 2 reports o_payload_err=2, o_pkt_good=0; packets 1 and 3 good; o_bad_pkts=1.
- Packet lengths 5, 7 and 4 (partial final words, empty payload): all good, proving discard-and-step alignment matches the transmitter.
- Inject count 32'h01234599 with RESYNC=1: o_count_err=1 on that packet; the next packet carrying 32'h0123459A is good. With RESYNC=0 the next packet reports o_count_err=1.
- 2-byte run → o_runt=1, o_pkt_good=0. The next packet with count 01 23 45 68 is good.
- Assert i_rst_seed mid-payload: no o_pkt_done, totals = 0, and the next seeded stream starting 01 23 45 67 is good. Assert i_rst_n low mid-packet: all outputs 0 asynchronously.
